// File: rtl/display7s_pkg.sv
// Shared definitions for the seven-segment display driver.
//
// Contents:
//   SEG_0..SEG_F  - active-low glyphs, bit order [0:6] = segments a..g
//   SEG_APAGADO   - all segments off
//   clog2_min1    - ceiling log2 clamped to a minimum of one bit, used to
//                   size counters so a parameter of 1 still yields a
//                   legal (1-bit) vector.
package display7s_pkg;

    localparam logic [0:6] SEG_0       = 7'b0000001;
    localparam logic [0:6] SEG_1       = 7'b1001111;
    localparam logic [0:6] SEG_2       = 7'b0010010;
    localparam logic [0:6] SEG_3       = 7'b0000110;
    localparam logic [0:6] SEG_4       = 7'b1001100;
    localparam logic [0:6] SEG_5       = 7'b0100100;
    localparam logic [0:6] SEG_6       = 7'b0100000;
    localparam logic [0:6] SEG_7       = 7'b0001111;
    localparam logic [0:6] SEG_8       = 7'b0000000;
    localparam logic [0:6] SEG_9       = 7'b0001100;
    localparam logic [0:6] SEG_A       = 7'b0001000;
    localparam logic [0:6] SEG_B       = 7'b1100000;
    localparam logic [0:6] SEG_C       = 7'b0110001;
    localparam logic [0:6] SEG_D       = 7'b1000010;
    localparam logic [0:6] SEG_E       = 7'b0110000;
    localparam logic [0:6] SEG_F       = 7'b0111000;
    localparam logic [0:6] SEG_APAGADO = 7'b1111111;

    // Number of bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/display7s_mux_seg7_decod_hex.sv
// seg7_decod_hex: combinational nibble-to-glyph decoder.
//
// Ports:
//   i_nibble   [3:0]  value to display
//   i_modo_hex        1 = hex glyphs 0-F, 0 = BCD (10-15 render blank)
//   o_segs     [0:6]  active-low segments a..g
module seg7_decod_hex
    import display7s_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_modo_hex,
    output logic [0:6] o_segs
);

    always_comb begin
        o_segs = SEG_APAGADO;
        case (i_nibble)
            4'h0: o_segs = SEG_0;
            4'h1: o_segs = SEG_1;
            4'h2: o_segs = SEG_2;
            4'h3: o_segs = SEG_3;
            4'h4: o_segs = SEG_4;
            4'h5: o_segs = SEG_5;
            4'h6: o_segs = SEG_6;
            4'h7: o_segs = SEG_7;
            4'h8: o_segs = SEG_8;
            4'h9: o_segs = SEG_9;
            4'hA: o_segs = SEG_A;
            4'hB: o_segs = SEG_B;
            4'hC: o_segs = SEG_C;
            4'hD: o_segs = SEG_D;
            4'hE: o_segs = SEG_E;
            4'hF: o_segs = SEG_F;
            default: o_segs = SEG_APAGADO;
        endcase
        // In BCD mode the letters are not valid digits: show nothing.
        if (!i_modo_hex && (i_nibble > 4'd9)) begin
            o_segs = SEG_APAGADO;
        end
    end

endmodule

// File: rtl/display7s_mux.sv
// display7s_mux: time-multiplexed driver for N common-anode 7-seg digits.
//
// A shadow register captures 'entrada' whenever 'carregar' is high; the
// outputs only ever read the shadow. A prescaler produces one tick every
// DIV cycles, and each tick advances the scan index to the next digit.
// The output stage registers the selected digit's anode and glyph, so
// outputs lag the index/shadow by exactly one clock.
//
// 'carregar' is a plain level-sampled load strobe with no back-pressure:
// every edge at which it is high copies 'entrada' into the shadow.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   entrada       packed value, nibble i = digit i (digit 0 rightmost)
//   carregar      load strobe
//   modo_hex      1 = hex glyphs, 0 = BCD (10-15 blank)
//   apagar_zeros  leading-zero blanking enable
//   apagar        global blank (anodes and segments off)
//   saida [0:6]   segments a..g, active-low
//   anodo         digit enables, active-low, one-hot-low
module display7s_mux
    import display7s_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int DIV       = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4*N_DIGITOS-1:0]   entrada,
    input  logic                     carregar,
    input  logic                     modo_hex,
    input  logic                     apagar_zeros,
    input  logic                     apagar,
    output logic [0:6]               saida,
    output logic [N_DIGITOS-1:0]     anodo
);

    localparam int PW = clog2_min1(DIV);
    localparam int IW = clog2_min1(N_DIGITOS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITOS - 1);

    logic [4*N_DIGITOS-1:0] r_shadow;
    logic [PW-1:0]          r_presc;
    logic [IW-1:0]          r_idx;
    logic [0:6]             r_saida;
    logic [N_DIGITOS-1:0]   r_anodo;

    logic                   w_tick;
    logic [3:0]             w_nibble;
    logic [N_DIGITOS-1:0]   w_anodo_sel;
    logic [N_DIGITOS-1:0]   w_zero_from;
    logic                   w_zero_acc;
    logic                   w_lz_blank;
    logic [0:6]             w_glyph;

    assign w_tick = (r_presc == PRESC_MAX);

    // Digit selection and leading-zero detection.
    // w_zero_from[i] is set when nibbles i..N-1 are all zero; it is built
    // from the most significant digit downwards as a running AND.
    always_comb begin
        w_nibble    = 4'h0;
        w_anodo_sel = '1;
        w_zero_from = '0;
        w_zero_acc  = 1'b1;
        w_lz_blank  = 1'b0;
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            w_zero_acc     = w_zero_acc & (r_shadow[4*i +: 4] == 4'h0);
            w_zero_from[i] = w_zero_acc;
        end
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nibble       = r_shadow[4*i +: 4];
                w_anodo_sel[i] = 1'b0;
                // Digit 0 is never blanked so a zero value still shows "0".
                w_lz_blank     = apagar_zeros && (i != 0) && w_zero_from[i];
            end
        end
    end

    seg7_decod_hex u_decod (
        .i_nibble   (w_nibble),
        .i_modo_hex (modo_hex),
        .o_segs     (w_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_presc  <= '0;
            r_idx    <= '0;
            r_saida  <= SEG_APAGADO;
            r_anodo  <= '1;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (carregar) begin
                r_shadow <= entrada;
            end

            // Priority: global blank, then leading-zero blank, then the
            // decoder (which itself blanks BCD-invalid nibbles).
            if (apagar) begin
                r_anodo <= '1;
                r_saida <= SEG_APAGADO;
            end else begin
                r_anodo <= w_anodo_sel;
                r_saida <= w_lz_blank ? SEG_APAGADO : w_glyph;
            end
        end
    end

    assign saida = r_saida;
    assign anodo = r_anodo;

endmodule

// File: tb/tb_display7s_mux.sv
module tb_display7s_mux;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] entrada;
    logic        carregar;
    logic        modo_hex;
    logic        apagar_zeros;
    logic        apagar;
    logic [0:6]  saida;
    logic [3:0]  anodo;
    logic [0:6]  saida1;
    logic [0:0]  anodo1;

    int total;
    int bad;

    // Scoreboards: {anodo, saida} expected at the next edge.
    logic [10:0] exp_q[$];
    logic [7:0]  exp1_q[$];

    // Reference model state.
    int          m_presc;
    int          m_idx;
    logic [15:0] m_shadow;
    logic [3:0]  m_shadow1;

    display7s_mux #(.N_DIGITOS(N), .DIV(DIV)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entrada      (entrada),
        .carregar     (carregar),
        .modo_hex     (modo_hex),
        .apagar_zeros (apagar_zeros),
        .apagar       (apagar),
        .saida        (saida),
        .anodo        (anodo)
    );

    display7s_mux #(.N_DIGITOS(1), .DIV(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .entrada      (entrada[3:0]),
        .carregar     (carregar),
        .modo_hex     (modo_hex),
        .apagar_zeros (apagar_zeros),
        .apagar       (apagar),
        .saida        (saida1),
        .anodo        (anodo1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:6] glyph(input logic [3:0] n, input logic hex);
        logic [0:6] g;
        case (n)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0001100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (!hex && n > 4'd9) g = 7'b1111111;
        return g;
    endfunction

    function automatic logic [10:0] exp_main();
        logic [3:0] an;
        logic [0:6] seg;
        logic [3:0] nib;
        logic       lz;
        an  = 4'b1111;
        seg = 7'b1111111;
        if (!apagar) begin
            an[m_idx] = 1'b0;
            nib = m_shadow[4*m_idx +: 4];
            lz  = apagar_zeros && (m_idx != 0) && ((m_shadow >> (4*m_idx)) == 16'h0);
            seg = lz ? 7'b1111111 : glyph(nib, modo_hex);
        end
        return {an, seg};
    endfunction

    function automatic logic [7:0] exp_single();
        if (apagar) return {1'b1, 7'b1111111};
        return {1'b0, glyph(m_shadow1, modo_hex)};
    endfunction

    // Driver: one clock with current inputs; model predicts, DUT is checked.
    task automatic cycle();
        logic [10:0] e;
        logic [7:0]  e1;
        exp_q.push_back(exp_main());
        exp1_q.push_back(exp_single());
        if (m_presc == DIV - 1) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % N;
        end else begin
            m_presc = m_presc + 1;
        end
        if (carregar) begin
            m_shadow  = entrada;
            m_shadow1 = entrada[3:0];
        end
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        e1 = exp1_q.pop_front();
        check("scan", {anodo, saida}, e);
        check("single", {anodo1, saida1}, e1);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input logic [15:0] v);
        entrada  = v;
        carregar = 1'b1;
        cycle();
        carregar = 1'b0;
    endtask

    // Asserts reset between edges and checks the outputs before any clock.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_seg", saida, 7'b1111111);
        check("rst_an", anodo, 4'b1111);
        check("rst_seg1", saida1, 7'b1111111);
        check("rst_an1", anodo1, 1'b1);
        m_presc   = 0;
        m_idx     = 0;
        m_shadow  = '0;
        m_shadow1 = '0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        entrada      = '0;
        carregar     = 1'b0;
        modo_hex     = 1'b1;
        apagar_zeros = 1'b0;
        apagar       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        async_reset();

        // First edge after release: digit 0 of shadow 0.
        cycle();
        check("first_an", anodo, 4'b1110);
        check("first_seg", saida, 7'b0000001);

        // Scan and wrap.
        load(16'h4321);
        run(20);

        // Hex vs BCD.
        load(16'h00AF);
        run(12);
        modo_hex = 1'b0;
        run(12);
        modo_hex = 1'b1;

        // Leading-zero blanking.
        apagar_zeros = 1'b1;
        load(16'h0050);
        run(12);
        load(16'h0000);
        run(12);
        apagar_zeros = 1'b0;

        // Global blank with scan still running, load during blank.
        apagar = 1'b1;
        run(3);
        load(16'h9876);
        run(5);
        apagar = 1'b0;
        run(8);

        // Load held high and loads coinciding with ticks.
        entrada  = 16'h1234;
        carregar = 1'b1;
        run(3);
        entrada  = 16'hBEEF;
        run(2);
        carregar = 1'b0;
        run(8);

        // Mid-operation reset.
        async_reset();
        run(6);

        // Randomised phase.
        for (int k = 0; k < 200; k++) begin
            entrada      = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            carregar     = ($urandom_range(0, 3) == 0);
            modo_hex     = 1'($urandom_range(0, 1));
            apagar_zeros = 1'($urandom_range(0, 1));
            apagar       = ($urandom_range(0, 7) == 0);
            cycle();
        end
        carregar = 1'b0;
        apagar   = 1'b0;
        run(4);

        check("drain", exp_q.size() + exp1_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
